palette_lut: RTL and testbench
==============================

# palette_lut

Parametrised, run-time writable colour palette for the VGA pixel path. It sits between the sprite/background compositor, which produces a palette index per pixel, and the VGA colour outputs. Entries are loaded at run time through a write port, and every looked-up colour is scaled by a global fade level. The fade level is driven by a built-in fade-in/fade-out sequencer used for screen transitions (level start, death, game over).

## Interface
- ENTRIES, 32, number of palette entries (≤ 2^IDX_W)
- IDX_W, 5, palette index width
- COLOR_W, 8, bits per colour channel
- FADE_W, 4, fade resolution; level range 0..2^FADE_W
- STEP_CYCLES, 2, clock cycles per fade level step (≥ 1)

- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- pix_idx_i  in  IDX_W  palette index of the current pixel
- pix_valid_i  in  1  pix_idx_i is meaningful this cycle
- wr_en_i  in  1  palette write strobe
- wr_addr_i  in  IDX_W  entry to write
- wr_rgb_i  in  3*COLOR_W  {R,G,B}, R in the MSBs
- fade_start_i  in  1  one-cycle request to start a fade
- fade_dir_i  in  1  0 = fade to black (target 0), 1 = fade in (target 2^FADE_W)
- red_o, green_o, blue_o  out  COLOR_W each  scaled colour
- pix_valid_o  out  1  outputs correspond to a valid input 2 cycles earlier
- transparent_o  out  1  pipelined flag: index was 0
- busy_o  out  1  high in INIT or FADING
- fade_done_o  out  1  one-cycle pulse when a fade reaches its target
- fade_level_o  out  FADE_W+1  current fade level

## Operation
- Storage: ENTRIES × 3*COLOR_W RAM, one write port and one read port.
- FSM states:
  - INIT (entered from Reset): writes {0,0,0} to entries 0..ENTRIES-1, one per cycle, then goes to IDLE. wr_en_i and fade_start_i are ignored in INIT. Lookups proceed normally and return 0 or stale data.
  - IDLE: fade_start_i=1 loads target from fade_dir_i, clears the step counter, and moves to FADING.
  - FADING: a step counter counts 0..STEP_CYCLES-1. On wrap, the level moves by 1 toward the target. When the level equals the target, fade_done_o pulses for 1 cycle and the FSM returns to IDLE. fade_start_i is ignored while FADING.
- Fade started with level already at target: FADING for one cycle, done pulse, no level change.
- Writes (IDLE/FADING): entry wr_addr_i ← wr_rgb_i. Writes with wr_addr_i ≥ ENTRIES are dropped.
- Lookup with pix_idx_i ≥ ENTRIES returns {0,0,0}; transparent_o=0.
- Read/write collision on the same address in the same cycle: the read returns the old contents (read-first).
- Scaling, per channel: out = (c × level) >> FADE_W.
  - Product width is COLOR_W+FADE_W+1.
  - The result always fits COLOR_W, with no saturation logic needed.
  - level = 2^FADE_W passes c unchanged; level = 0 gives 0.
- The fade level applies to the whole frame as it changes. No frame-boundary synchronisation is done here.

## Timing
- Lookup latency is 2 cycles:
  - Stage 1: RAM read; valid and the index-0 flag registered.
  - Stage 2: multiply/shift; all colour outputs registered.
- Throughput: 1 pixel per cycle, no stalls, no back-pressure.
- The scale in stage 2 uses fade_level_o as sampled at stage 2.
- Reset values: red/green/blue_o=0, pix_valid_o=0, transparent_o=0, busy_o=1 (INIT), fade_done_o=0, fade_level_o=2^FADE_W. Pipeline valids cleared.
- Init duration: busy_o deasserts exactly ENTRIES cycles after Reset falls.
- Full fade duration: 2^FADE_W × STEP_CYCLES cycles from the start-accept edge to the last level change. fade_done_o is asserted in the cycle after that change; busy_o drops in the same cycle.
- Reset asserted mid-fade or mid-init: immediate return to INIT with level = full. No done pulse. In-flight pixels are discarded.

## Test plan
- Reset, then wait: busy_o=1 for 32 cycles, then 0. Lookup of idx 7 → {0,0,0} with pix_valid_o 2 cycles later.
- Write idx 10 = {250,0,0}, then look up idx 10 → {250,0,0} after 2 cycles. Look up idx 0 → transparent_o=1. Look up idx 40 (IDX_W=6 build) → {0,0,0}.
- Write and read idx 5 in the same cycle (old {0,80,250}, new {250,250,250}) → old value returned. Next lookup → {250,250,250}.
- Fade out (dir=0) with idx 10 streaming every cycle:
  - level 16→0 over 32 cycles.
  - At level 8, red_o=125; at level 0, red_o=0.
  - fade_done_o pulses once; a second fade_start_i mid-fade is ignored.
- Fade in from 0 → level 16, red_o returns to 250. fade_start_i with dir=1 at level 16 → done pulse 1 cycle later, level unchanged.
- Reset asserted at level 9 mid-fade → next cycle level=16, busy_o=1, outputs 0, fade_done_o never pulses.

Source files
------------

// File: rtl/palette_lut.sv
// palette_lut: run-time writable colour palette with a global fade-level scaler and fade sequencer
module palette_lut #(
    parameter int ENTRIES     = 32,
    parameter int IDX_W       = 5,
    parameter int COLOR_W     = 8,
    parameter int FADE_W      = 4,
    parameter int STEP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       pix_idx_i,
    input  logic                   pix_valid_i,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_addr_i,
    input  logic [3*COLOR_W-1:0]   wr_rgb_i,
    input  logic                   fade_start_i,
    input  logic                   fade_dir_i,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   pix_valid_o,
    output logic                   transparent_o,
    output logic                   busy_o,
    output logic                   fade_done_o,
    output logic [FADE_W:0]        fade_level_o
);
    localparam int RGB_W  = 3 * COLOR_W;
    localparam int LVL_W  = FADE_W + 1;
    localparam int PROD_W = COLOR_W + FADE_W + 1;
    localparam int AW     = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(1 << FADE_W);

    typedef enum logic [1:0] {INIT, IDLE, FADING} state_t;

    state_t            state, state_n;
    logic [AW-1:0]     init_cnt, init_cnt_n;
    logic [STEP_W-1:0] step, step_n;
    logic [LVL_W-1:0]  level, level_n, target, target_n;
    logic              done_n;
    logic [RGB_W-1:0]  mem [ENTRIES];
    logic [RGB_W-1:0]  rd_q, wdata;
    logic [AW-1:0]     waddr;
    logic              we, v1, t1, r1;

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c, input logic [LVL_W-1:0] l);
        return COLOR_W'((PROD_W'(c) * PROD_W'(l)) >> FADE_W);
    endfunction

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        step_n     = step;
        level_n    = level;
        target_n   = target;
        done_n     = 1'b0;
        unique case (state)
            INIT: begin
                init_cnt_n = init_cnt + AW'(1);
                state_n    = init_cnt == AW'(ENTRIES - 1) ? IDLE : INIT;
            end
            IDLE: begin
                if (fade_start_i) begin
                    target_n = fade_dir_i ? FULL : '0;
                    step_n   = '0;
                    state_n  = FADING;
                end
            end
            FADING: begin
                if (level == target) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (step == STEP_W'(STEP_CYCLES - 1)) begin
                    step_n  = '0;
                    level_n = level < target ? level + LVL_W'(1) : level - LVL_W'(1);
                end else begin
                    step_n = step + STEP_W'(1);
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_cnt    <= '0;
            step        <= '0;
            level       <= FULL;
            target      <= FULL;
            fade_done_o <= 1'b0;
        end else begin
            state       <= state_n;
            init_cnt    <= init_cnt_n;
            step        <= step_n;
            level       <= level_n;
            target      <= target_n;
            fade_done_o <= done_n;
        end
    end

    // INIT owns the write port while clearing; out-of-range user writes are dropped
    assign we    = state == INIT || (wr_en_i && {1'b0, wr_addr_i} < (IDX_W + 1)'(ENTRIES));
    assign waddr = state == INIT ? init_cnt : wr_addr_i[AW-1:0];
    assign wdata = state == INIT ? '0 : wr_rgb_i;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_q <= mem[pix_idx_i[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            t1            <= 1'b0;
            r1            <= 1'b0;
            pix_valid_o   <= 1'b0;
            transparent_o <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
        end else begin
            v1            <= pix_valid_i;
            t1            <= pix_idx_i == '0;
            r1            <= {1'b0, pix_idx_i} < (IDX_W + 1)'(ENTRIES);
            pix_valid_o   <= v1;
            transparent_o <= t1;
            red_o         <= r1 ? scale(rd_q[RGB_W-1 -: COLOR_W], level) : '0;
            green_o       <= r1 ? scale(rd_q[2*COLOR_W-1 -: COLOR_W], level) : '0;
            blue_o        <= r1 ? scale(rd_q[COLOR_W-1:0], level) : '0;
        end
    end

    assign busy_o       = state != IDLE;
    assign fade_level_o = level;
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: scoreboard bench against a behavioural palette and fade-timeline model
module tb_palette_lut;
    localparam int ENT  = 32;
    localparam int IW   = 6;
    localparam int CW   = 8;
    localparam int FW   = 4;
    localparam int STEP = 2;
    localparam int FULL = 16;

    typedef struct {
        logic [3*CW:0] v;
        int            edge_n;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pv = 1'b0, we = 1'b0, fs = 1'b0, fd = 1'b0;
    logic [IW-1:0] pidx = '0, wa = '0;
    logic [3*CW-1:0] rgb = '0;
    logic [CW-1:0] red_o, green_o, blue_o;
    logic pix_valid_o, transparent_o, busy_o, fade_done_o;
    logic [FW:0] fade_level_o;

    int checks = 0, errors = 0, e = 0;
    int init_end = 1 << 30, d_edge = -1, fa = 0, fbase = FULL, ftgt = FULL, fdist = 0, cur_level = FULL;
    logic busy_exp = 1'b1, done_exp = 1'b0;
    logic [3*CW-1:0] mmem [ENT];
    item_t sb[$];
    item_t it;

    always #5 clk = ~clk;

    palette_lut #(
        .ENTRIES(ENT), .IDX_W(IW), .COLOR_W(CW), .FADE_W(FW), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_idx_i(pidx), .pix_valid_i(pv),
        .wr_en_i(we), .wr_addr_i(wa), .wr_rgb_i(rgb),
        .fade_start_i(fs), .fade_dir_i(fd),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .pix_valid_o(pix_valid_o), .transparent_o(transparent_o),
        .busy_o(busy_o), .fade_done_o(fade_done_o), .fade_level_o(fade_level_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, e, act, exp);
        end
    endtask

    // level after edge ee: one step toward the target every STEP edges since the accept edge
    function automatic int lvl_at(input int ee);
        int k;
        k = (ee - fa) / STEP;
        if (k > fdist) k = fdist;
        return ftgt >= fbase ? fbase + k : fbase - k;
    endfunction

    function automatic logic [CW-1:0] sc(input logic [CW-1:0] c);
        return CW'(int'(c) * cur_level / FULL);
    endfunction

    task automatic model();
        logic [3*CW-1:0] rd;
        e++;
        if (rst) begin
            init_end  = e + ENT;
            fa        = e;
            fbase     = FULL;
            ftgt      = FULL;
            fdist     = 0;
            d_edge    = -1;
            cur_level = FULL;
            busy_exp  = 1'b1;
            done_exp  = 1'b0;
            sb.delete();
            foreach (mmem[i]) mmem[i] = '0;
        end else begin
            rd = int'(pidx) < ENT ? mmem[pidx[4:0]] : '0;
            if (fs && e > init_end && e > d_edge) begin
                fbase  = cur_level;
                ftgt   = fd ? FULL : 0;
                fa     = e;
                fdist  = ftgt > fbase ? ftgt - fbase : fbase - ftgt;
                d_edge = e + fdist * STEP + 1;
            end
            cur_level = lvl_at(e);
            busy_exp  = e < init_end || e < d_edge;
            done_exp  = e == d_edge;
            if (pv)
                sb.push_back('{v: {sc(rd[23:16]), sc(rd[15:8]), sc(rd[7:0]), pidx == '0}, edge_n: e + 1});
            if (we && e > init_end && int'(wa) < ENT)
                mmem[wa[4:0]] = rgb;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("fade_level", 32'(fade_level_o), 32'(cur_level));
        chk("busy", 32'(busy_o), 32'(busy_exp));
        chk("fade_done", 32'(fade_done_o), 32'(done_exp));
        if (rst)
            chk("reset_outputs", 32'({red_o, green_o, blue_o, pix_valid_o, transparent_o}), 32'd0);
        pv = 1'b0;
        we = 1'b0;
        fs = 1'b0;
    endtask

    task automatic look(input int idx);
        pv   = 1'b1;
        pidx = IW'(idx);
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        we  = 1'b1;
        wa  = IW'(a);
        rgb = d;
    endtask

    task automatic fade(input logic dir);
        fs = 1'b1;
        fd = dir;
    endtask

    task automatic rand_in(input bit allow_fade);
        pv   = (e >= init_end) && ($urandom_range(0, 3) != 0);
        pidx = IW'($urandom_range(0, 7) == 0 ? $urandom_range(32, 63) : $urandom_range(0, 31));
        we   = $urandom_range(0, 2) == 0;
        wa   = IW'($urandom_range(0, 7) == 0 ? $urandom_range(32, 63) : $urandom_range(0, 31));
        rgb  = 24'($urandom);
        fs   = allow_fade && $urandom_range(0, 40) == 0;
        fd   = 1'($urandom_range(0, 1));
    endtask

    task automatic settle();
        for (int k = 0; k < 200 && e <= d_edge; k++) step();
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_n < e) begin
            checks++;
            errors++;
            $display("FAIL lost_pixel at edge %0d: pix_valid_o never rose, expected pixel at edge %0d", e, sb[0].edge_n);
            void'(sb.pop_front());
        end
        if (pix_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pixel at edge %0d: got pix_valid_o=1, expected 0", e);
            end else begin
                it = sb.pop_front();
                chk("pixel_latency", 32'(e), 32'(it.edge_n));
                chk("pixel_rgb_transp", 32'({red_o, green_o, blue_o, transparent_o}), 32'(it.v));
            end
        end
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        repeat (34) step();
        look(7); step();
        wr(10, 24'hFA0000); step();
        look(10); step();
        look(0); step();
        look(40); step();
        wr(5, {8'd0, 8'd80, 8'd250}); step();
        wr(5, {8'd250, 8'd250, 8'd250}); look(5); step();
        look(5); step();
        for (int i = 0; i < 300; i++) begin rand_in(1'b1); step(); end
        settle();
        fade(1'b1); step();
        settle();
        wr(10, 24'hFA0000); step();
        fade(1'b0); look(10); step();
        for (int k = 0; k < 40; k++) begin
            look(10);
            if (k == 12) fade(1'b1);
            step();
        end
        fade(1'b1); look(10); step();
        for (int k = 0; k < 40; k++) begin look(10); step(); end
        fade(1'b1); look(10); step();
        repeat (3) begin look(10); step(); end
        fade(1'b0); step();
        for (int k = 0; k < 100 && cur_level != 9; k++) begin look(10); step(); end
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (40) step();
        for (int i = 0; i < 150; i++) begin rand_in(1'b1); step(); end
        repeat (5) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
